// File: rtl/collision_frame_monitor_if.sv
// -----------------------------------------------------------------------------
// collision_frame_monitor_if
//   Bundles the pixel-stream inputs and the per-frame result outputs of
//   collision_frame_monitor. The clock and reset are not part of the bundle.
//
//   master : the producer / consumer side (drives the pixel stream and ack,
//            observes the frame results)
//   slave  : the monitor itself
//
//   pixel_valid     current cycle carries an active-display pixel sample
//   frame_start     one-cycle pulse on the first cycle of a new frame
//   collision_num   signed number of components enabled at this pixel
//   event_ack       clears collision_event
//   frame_total     colliding-pixel count of the last completed frame
//   frame_peak      max collision_num of the last completed frame (sat. 255)
//   frame_count     completed frames since reset (wrapping)
//   frame_done      one-cycle pulse when frame_total/frame_peak update
//   collision_event sticky flag: last latched frame met the threshold
//   hist            per-frame hit history (zero unless COLLISION_HIST_EN)
// -----------------------------------------------------------------------------
interface collision_frame_monitor_if #(
  parameter int COUNT_W = 20,
  parameter int FCNT_W  = 16
);
  logic                pixel_valid;
  logic                frame_start;
  logic signed [31:0]  collision_num;
  logic                event_ack;
  logic [COUNT_W-1:0]  frame_total;
  logic [7:0]          frame_peak;
  logic [FCNT_W-1:0]   frame_count;
  logic                frame_done;
  logic                collision_event;
  logic [7:0]          hist;

  modport master (
    output pixel_valid, frame_start, collision_num, event_ack,
    input  frame_total, frame_peak, frame_count, frame_done,
           collision_event, hist
  );

  modport slave (
    input  pixel_valid, frame_start, collision_num, event_ack,
    output frame_total, frame_peak, frame_count, frame_done,
           collision_event, hist
  );
endinterface

// File: rtl/collision_frame_monitor.sv
// -----------------------------------------------------------------------------
// collision_frame_monitor
//   Consumes the registered per-pixel collision count from the pixel-join
//   stage. Within each frame it counts colliding pixels (count >= 2) in a
//   saturating accumulator and tracks the peak overlap depth. At every
//   frame_start the running results are latched to the outputs, a frame
//   counter advances, and a sticky collision_event is raised when the latched
//   total reaches THRESHOLD.
//
//   Ports : clock, reset (synchronous, active-high), bus (slave modport of
//           collision_frame_monitor_if; see that file for signal meanings).
//   Params: COUNT_W   accumulator / frame_total width (saturating)
//           THRESHOLD minimum latched total that sets collision_event; 0 = off
//           FCNT_W    frame_count width (wrapping)
//   Macro : COLLISION_HIST_EN builds the 8-bit per-frame hit history on hist;
//           without it hist is tied to zero.
// -----------------------------------------------------------------------------
module collision_frame_monitor #(
  parameter int          COUNT_W   = 20,
  parameter int unsigned THRESHOLD = 1,
  parameter int          FCNT_W    = 16
) (
  input logic                     clock,
  input logic                     reset,
  collision_frame_monitor_if.slave bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [COUNT_W-1:0] ACC_MAX = '1;
  // Threshold compare is done at >= 32 bits so a THRESHOLD wider than the
  // accumulator can never be met instead of being silently truncated.
  localparam int                 CMP_W   = (COUNT_W > 32) ? COUNT_W : 32;
  localparam logic [CMP_W-1:0]   THRESH  = CMP_W'(THRESHOLD);

  state_t             state;
  logic [COUNT_W-1:0] acc;
  logic [7:0]         peak_reg;
  logic [COUNT_W-1:0] frame_total_q;
  logic [7:0]         frame_peak_q;
  logic [FCNT_W-1:0]  frame_count_q;
  logic               frame_done_q;
  logic               event_q;

  // Sanitised sample: negative counts read as zero, peak clamps at 255.
  logic       sample_hit;
  logic [7:0] sample_peak;
  logic       meets_thresh;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sample_hit  = 1'b0;
    sample_peak = 8'd0;
    if (bus.pixel_valid) begin
      sample_hit = (bus.collision_num >= 32'sd2);
      if (bus.collision_num > 32'sd255)
        sample_peak = 8'd255;
      else if (bus.collision_num > 32'sd0)
        sample_peak = bus.collision_num[7:0];
    end
  end

  assign meets_thresh = (THRESHOLD != 0) && (CMP_W'(acc) >= THRESH);

  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state         <= IDLE;
      acc           <= '0;
      peak_reg      <= '0;
      frame_total_q <= '0;
      frame_peak_q  <= '0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
      event_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.event_ack) event_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            state    <= ACCUM;
            acc      <= sample_hit ? COUNT_W'(1) : '0;
            peak_reg <= sample_peak;
          end
        end

        ACCUM: begin
          if (bus.frame_start) begin
            frame_total_q <= acc;
            frame_peak_q  <= peak_reg;
            frame_count_q <= frame_count_q + FCNT_W'(1);
            frame_done_q  <= 1'b1;
            // A qualifying latch overrides a same-cycle ack; a
            // non-qualifying one leaves the flag untouched.
            if (meets_thresh) event_q <= 1'b1;
            // The frame_start sample is the first pixel of the new frame.
            acc      <= sample_hit ? COUNT_W'(1) : '0;
            peak_reg <= sample_peak;
          end else begin
            if (sample_hit && acc != ACC_MAX) acc <= acc + COUNT_W'(1);
            if (sample_peak > peak_reg)       peak_reg <= sample_peak;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef COLLISION_HIST_EN
  logic [7:0] hist_q;

  always_ff @(posedge clock) begin
    if (reset)
      hist_q <= '0;
    else if (state == ACCUM && bus.frame_start)
      hist_q <= {hist_q[6:0], (acc != '0)};
  end

  assign bus.hist = hist_q;
`else
  assign bus.hist = 8'd0;
`endif

  assign bus.frame_total     = frame_total_q;
  assign bus.frame_peak      = frame_peak_q;
  assign bus.frame_count     = frame_count_q;
  assign bus.frame_done      = frame_done_q;
  assign bus.collision_event = event_q;

endmodule

// File: tb/tb_collision_frame_monitor.sv
// -----------------------------------------------------------------------------
// tb_collision_frame_monitor
//   Two monitors share one stimulus stream:
//     dut     : default parameters (COUNT_W=20, THRESHOLD=1)
//     dut_sat : COUNT_W=4, THRESHOLD=0 (saturation, event disabled)
//   A cycle table covers the main frame flow; short hand-written sequences
//   cover IDLE behaviour, saturation, mid-frame reset and the hit history.
// -----------------------------------------------------------------------------
module tb_collision_frame_monitor;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  collision_frame_monitor_if #(.COUNT_W(20), .FCNT_W(16)) bus ();
  collision_frame_monitor_if #(.COUNT_W(4),  .FCNT_W(16)) bus_sat ();

  assign bus_sat.pixel_valid   = bus.pixel_valid;
  assign bus_sat.frame_start   = bus.frame_start;
  assign bus_sat.collision_num = bus.collision_num;
  assign bus_sat.event_ack     = bus.event_ack;

  collision_frame_monitor #(.COUNT_W(20), .THRESHOLD(1), .FCNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  collision_frame_monitor #(.COUNT_W(4), .THRESHOLD(0), .FCNT_W(16)) dut_sat (
    .clock (clock),
    .reset (reset),
    .bus   (bus_sat.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One cycle: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic pv, input logic fs, input int num, input logic ack);
    @(negedge clock);
    bus.pixel_valid   = pv;
    bus.frame_start   = fs;
    bus.collision_num = num;
    bus.event_ack     = ack;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset             = 1'b1;
    bus.pixel_valid   = 1'b0;
    bus.frame_start   = 1'b0;
    bus.collision_num = 0;
    bus.event_ack     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " total"}, bus.frame_total, 0);
    check({tag, " peak"},  bus.frame_peak, 0);
    check({tag, " count"}, bus.frame_count, 0);
    check({tag, " done"},  bus.frame_done, 0);
    check({tag, " event"}, bus.collision_event, 0);
    check({tag, " hist"},  bus.hist, 0);
  endtask

  typedef struct {
    logic pv;
    logic fs;
    int   num;
    logic ack;
    int   total;
    int   peak;
    int   count;
    logic done;
    logic evt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic pv, logic fs, int num, logic ack,
                              int total, int peak, int count, logic done, logic evt);
    vec_t v;
    v.pv = pv; v.fs = fs; v.num = num; v.ack = ack;
    v.total = total; v.peak = peak; v.count = count; v.done = done; v.evt = evt;
    return v;
  endfunction

  initial begin
    int samples[9];
    logic [7:0] hist_exp;

    samples = '{2, 3, 0, 1, 2, 0, 0, 5, 1};
    // Frame 1: samples 2,3,0,1,2,0,0,5,1 then frame_start on a sample of 2
    // (that sample goes to frame 2) -> total 4, peak 5.
    vecs[0] = mk(0, 1, 0, 0,   0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) vecs[i+1] = mk(1, 0, samples[i], 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 1,   2, 0,   4,   5, 1, 1, 1);
    vecs[11] = mk(0, 0,   0, 1,   4,   5, 1, 0, 0);  // ack alone clears
    vecs[12] = mk(1, 1, 300, 0,   1,   2, 2, 1, 1);  // frame 2 = the carried sample
    vecs[13] = mk(1, 0,  -3, 0,   1,   2, 2, 0, 1);  // negative: no hit, no peak
    vecs[14] = mk(0, 1,   0, 1,   1, 255, 3, 1, 1);  // set beats ack; 300 -> 255
    vecs[15] = mk(0, 1,   0, 0,   0,   0, 4, 1, 1);  // zero-length frame keeps event
    vecs[16] = mk(0, 0,   0, 1,   0,   0, 4, 0, 0);
    vecs[17] = mk(1, 0,   4, 0,   0,   0, 4, 0, 0);
    vecs[18] = mk(1, 1,   3, 0,   1,   4, 5, 1, 1);  // coincident 3 excluded
    vecs[19] = mk(0, 1,   0, 0,   1,   3, 6, 1, 1);  // ...and included in next frame

    // ---------------- reset state ----------------
    do_reset();
    #1;
    check_all_zero("reset");

    // ---------------- table-driven main flow ----------------
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].pv, vecs[i].fs, vecs[i].num, vecs[i].ack);
      check($sformatf("v%0d total", i), bus.frame_total,     vecs[i].total);
      check($sformatf("v%0d peak", i),  bus.frame_peak,      vecs[i].peak);
      check($sformatf("v%0d count", i), bus.frame_count,     vecs[i].count);
      check($sformatf("v%0d done", i),  bus.frame_done,      vecs[i].done);
      check($sformatf("v%0d event", i), bus.collision_event, vecs[i].evt);
    end

    // ---------------- IDLE ignores samples; back-to-back frame_start -------
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 4, 0);
    check_all_zero("idle");
    step(0, 1, 0, 0);
    check("b2b first count", bus.frame_count, 0);
    check("b2b first done",  bus.frame_done, 0);
    step(0, 1, 0, 0);
    check("b2b total", bus.frame_total, 0);
    check("b2b peak",  bus.frame_peak, 0);
    check("b2b count", bus.frame_count, 1);
    check("b2b done",  bus.frame_done, 1);
    check("b2b event", bus.collision_event, 0);

    // ---------------- saturation / clamping ----------------
    do_reset();
    step(0, 1, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 0, 2, 0);
    step(1, 0, 300, 0);
    step(1, 0, -3, 0);
    step(0, 1, 0, 0);
    check("sat total",      bus_sat.frame_total, 15);
    check("sat peak",       bus_sat.frame_peak, 255);
    check("sat event off",  bus_sat.collision_event, 0);
    check("sat done",       bus_sat.frame_done, 1);
    check("wide total",     bus.frame_total, 41);
    check("wide peak",      bus.frame_peak, 255);
    check("wide event",     bus.collision_event, 1);

    // ---------------- reset mid-frame ----------------
    step(1, 0, 3, 0);
    step(1, 0, 3, 0);
    @(negedge clock);
    reset             = 1'b1;
    bus.pixel_valid   = 1'b1;
    bus.frame_start   = 1'b1;
    bus.collision_num = 3;
    bus.event_ack     = 1'b0;
    @(posedge clock);
    #1;
    check_all_zero("midreset");
    @(negedge clock);
    reset = 1'b0;
    bus.frame_start = 1'b0;
    step(1, 0, 3, 0);                 // must be ignored: back in IDLE
    check("midreset idle done", bus.frame_done, 0);
    step(0, 1, 0, 0);                 // enters ACCUM, no latch
    check("midreset start done", bus.frame_done, 0);
    step(0, 1, 0, 0);
    check("midreset latch total", bus.frame_total, 0);
    check("midreset latch count", bus.frame_count, 1);

    // ---------------- hit history: totals 3, 0, 1 ----------------
    do_reset();
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 2, 0);
    step(0, 1, 0, 0);
    check("hist f1 total", bus.frame_total, 3);
    step(0, 1, 0, 0);
    check("hist f2 total", bus.frame_total, 0);
    step(1, 0, 7, 0);
    step(0, 1, 0, 0);
    check("hist f3 total", bus.frame_total, 1);
`ifdef COLLISION_HIST_EN
    hist_exp = 8'b0000_0101;
`else
    hist_exp = 8'b0000_0000;
`endif
    check("hist",     bus.hist, hist_exp);
    check("hist sat", bus_sat.hist, hist_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
